// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, FSM encodings, reboot address.
package pipe_ctrl_pkg;

    localparam logic [31:0] REBOOT_ADDR = 32'h0000_0200;

    // Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
    localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_IRQ_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests and sequences trap/irq/mret redirects
// into a FLUSH_CYCLES-long flush with the redirect PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(REBOOT_ADDR)
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              stall_req_if_i,
    input  logic              stall_req_id_i,
    input  logic              stall_req_ex_i,
    input  logic              stall_req_mem_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              mret_req_i,
    input  logic [ADDR_W-1:0] mepc_i,
    input  logic              irq_i,
    input  logic              irq_en_i,
    input  logic [ADDR_W-1:0] mem_pc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] trap_pc_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              epc_we_o,
    output logic              irq_ack_o
);

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [2:0] fcnt;
    logic       irq_pend;
    logic       take_trap;
    logic       take_irq;
    logic       take_mret;

    assign irq_pend = irq_i & irq_en_i;
    assign flush_o  = (state == ST_FLUSH);

    // Shallow priority chain straight from the request pins; flush overrides any stall.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        stall_o = STALL_NONE;
        if (state != ST_FLUSH) begin
            if (stall_req_mem_i)     stall_o = STALL_FROM_MEM;
            else if (stall_req_ex_i) stall_o = STALL_FROM_EX;
            else if (stall_req_id_i) stall_o = STALL_FROM_ID;
            else if (stall_req_if_i) stall_o = STALL_FROM_IF;
        end
    end

    always_comb begin
        take_trap  = 1'b0;
        take_irq   = 1'b0;
        take_mret  = 1'b0;
        next_state = state;
        case (state)
            ST_RUN: begin
                if (trap_req_i)                         take_trap  = 1'b1;
                else if (irq_pend && !stall_req_mem_i)  take_irq   = 1'b1;
                else if (irq_pend)                      next_state = ST_IRQ_WAIT;
                else if (mret_req_i)                    take_mret  = 1'b1;
            end
            ST_IRQ_WAIT: begin
                // An mret is not taken here; the pending interrupt outranks it.
                if (trap_req_i)                         take_trap  = 1'b1;
                else if (irq_pend && !stall_req_mem_i)  take_irq   = 1'b1;
                else if (!irq_pend)                     next_state = ST_RUN;
            end
            ST_FLUSH: next_state = ST_FLUSH;
            default:  next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!n_rst_i) begin
            state     <= ST_RUN;
            fcnt      <= 3'd0;
            epc_we_o  <= 1'b0;
            irq_ack_o <= 1'b0;
            trap_pc_o <= RESET_PC;
            epc_o     <= '0;
        end else begin
            epc_we_o  <= take_trap | take_irq;
            irq_ack_o <= take_irq;
            if (take_trap || take_irq) begin
                trap_pc_o <= trap_vec_i;
                epc_o     <= mem_pc_i;
                state     <= ST_FLUSH;
                fcnt      <= FCNT_LOAD;
            end else if (take_mret) begin
                trap_pc_o <= mepc_i;
                state     <= ST_FLUSH;
                fcnt      <= FCNT_LOAD;
            end else if (state == ST_FLUSH) begin
                if (fcnt == 3'd0) state <= ST_RUN;
                else              fcnt  <= fcnt - 3'd1;
            end else begin
                state <= next_state;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus a randomized run compared
// every cycle against a behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int          FC    = 2;
    localparam logic [31:0] RST_PC = REBOOT_ADDR;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i;
    logic        trap_req_i, mret_req_i, irq_i, irq_en_i;
    logic [31:0] trap_vec_i, mepc_i, mem_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o, epc_we_o, irq_ack_o;
    logic [31:0] trap_pc_o, epc_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC), .RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i),
        .stall_req_if_i(stall_req_if_i), .stall_req_id_i(stall_req_id_i),
        .stall_req_ex_i(stall_req_ex_i), .stall_req_mem_i(stall_req_mem_i),
        .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
        .mret_req_i(mret_req_i), .mepc_i(mepc_i),
        .irq_i(irq_i), .irq_en_i(irq_en_i), .mem_pc_i(mem_pc_i),
        .stall_o(stall_o), .flush_o(flush_o), .trap_pc_o(trap_pc_o),
        .epc_o(epc_o), .epc_we_o(epc_we_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining flush cycles, a pending-irq flag and the registered outputs.
    typedef struct {
        int          flush_left;
        bit          waiting;
        logic [31:0] pc;
        logic [31:0] epc;
        bit          we;
        bit          ack;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur);
        model_t nx = cur;
        bit irqp = irq_i & irq_en_i;
        nx.we  = 1'b0;
        nx.ack = 1'b0;
        if (!n_rst_i) begin
            nx.flush_left = 0; nx.waiting = 1'b0;
            nx.pc = RST_PC; nx.epc = '0;
        end else if (cur.flush_left > 0) begin
            nx.flush_left = cur.flush_left - 1;
        end else if (trap_req_i || (irqp && !stall_req_mem_i)) begin
            nx.pc = trap_vec_i; nx.epc = mem_pc_i; nx.we = 1'b1;
            nx.ack = !trap_req_i;
            nx.flush_left = FC; nx.waiting = 1'b0;
        end else if (irqp) begin
            nx.waiting = 1'b1;
        end else if (cur.waiting) begin
            nx.waiting = 1'b0;
        end else if (mret_req_i) begin
            nx.pc = mepc_i; nx.flush_left = FC;
        end
        return nx;
    endfunction

    function automatic logic [5:0] model_stall(input model_t cur);
        int n;
        if (cur.flush_left > 0) return 6'd0;
        n = stall_req_mem_i ? 5 : stall_req_ex_i ? 4 : stall_req_id_i ? 3 : stall_req_if_i ? 2 : 0;
        return 6'((1 << n) - 1);
    endfunction

    always @(posedge clk_i) m <= model_step(m);

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall", 64'(stall_o), 64'(model_stall(m)));
            check("flush", 64'(flush_o), 64'(m.flush_left > 0));
            check("trap_pc", 64'(trap_pc_o), 64'(m.pc));
            check("epc", 64'(epc_o), 64'(m.epc));
            check("epc_we", 64'(epc_we_o), 64'(m.we));
            check("irq_ack", 64'(irq_ack_o), 64'(m.ack));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        stall_req_if_i = 0; stall_req_id_i = 0; stall_req_ex_i = 0; stall_req_mem_i = 0;
        trap_req_i = 0; mret_req_i = 0; irq_i = 0; irq_en_i = 0;
    endtask

    initial begin
        n_rst_i = 1'b0;
        idle();
        trap_vec_i = '0; mepc_i = '0; mem_pc_i = '0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_flush", 64'(flush_o), 64'd0);
        check("rst_trap_pc", 64'(trap_pc_o), 64'(RST_PC));
        check("rst_epc", 64'(epc_o), 64'd0);
        check("rst_epc_we", 64'(epc_we_o), 64'd0);
        check("rst_irq_ack", 64'(irq_ack_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        n_rst_i = 1'b1;
        tick();

        // Stall merge
        stall_req_id_i = 1; stall_req_mem_i = 1; #1;
        check("merge_id_mem", 64'(stall_o), 64'b011111);
        stall_req_mem_i = 0; #1;
        check("merge_id", 64'(stall_o), 64'b000111);
        stall_req_id_i = 0;
        tick();

        // Trap
        trap_vec_i = 32'h8000_0100; mem_pc_i = 32'h0000_0040; trap_req_i = 1;
        tick();
        trap_req_i = 0; stall_req_mem_i = 1; #1;
        check("trap_flush0", 64'(flush_o), 64'd1);
        check("trap_pc", 64'(trap_pc_o), 64'h8000_0100);
        check("trap_epc", 64'(epc_o), 64'h40);
        check("trap_we0", 64'(epc_we_o), 64'd1);
        check("trap_stall", 64'(stall_o), 64'd0);
        stall_req_mem_i = 0;
        tick();
        check("trap_flush1", 64'(flush_o), 64'd1);
        check("trap_we1", 64'(epc_we_o), 64'd0);
        tick();
        check("trap_flush2", 64'(flush_o), 64'd0);

        // Irq deferred by MEM stall
        irq_i = 1; irq_en_i = 1; stall_req_mem_i = 1; mem_pc_i = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("defer_flush", 64'(flush_o), 64'd0);
            check("defer_ack", 64'(irq_ack_o), 64'd0);
        end
        stall_req_mem_i = 0;
        tick();
        check("irq_ack", 64'(irq_ack_o), 64'd1);
        check("irq_we", 64'(epc_we_o), 64'd1);
        check("irq_flush", 64'(flush_o), 64'd1);
        check("irq_epc", 64'(epc_o), 64'h80);
        irq_i = 0;
        tick(); tick();

        // Simultaneous trap, irq and mret
        trap_vec_i = 32'h8000_0200; mepc_i = 32'h0000_1234;
        trap_req_i = 1; irq_i = 1; irq_en_i = 1; mret_req_i = 1;
        tick();
        trap_req_i = 0; mret_req_i = 0;
        check("sim_ack", 64'(irq_ack_o), 64'd0);
        check("sim_pc", 64'(trap_pc_o), 64'h8000_0200);
        check("sim_we", 64'(epc_we_o), 64'd1);
        tick(); tick();
        check("sim_exit", 64'(flush_o), 64'd0);
        tick();
        check("sim_irq_ack", 64'(irq_ack_o), 64'd1);
        check("sim_irq_flush", 64'(flush_o), 64'd1);
        irq_i = 0;
        tick(); tick();

        // Mret, with a trap pulse during the flush
        mepc_i = 32'h0000_1234; mret_req_i = 1;
        tick();
        mret_req_i = 0; trap_req_i = 1; trap_vec_i = 32'hDEAD_0000;
        check("mret_pc", 64'(trap_pc_o), 64'h1234);
        check("mret_flush", 64'(flush_o), 64'd1);
        check("mret_we", 64'(epc_we_o), 64'd0);
        tick();
        trap_req_i = 0;
        check("mret_flush1", 64'(flush_o), 64'd1);
        tick();
        check("mret_exit", 64'(flush_o), 64'd0);
        check("mret_ignored_trap", 64'(trap_pc_o), 64'h1234);
        tick();
        check("mret_no_redirect", 64'(flush_o), 64'd0);

        // Reset mid-flush
        mepc_i = 32'h0000_5678; mret_req_i = 1;
        tick();
        mret_req_i = 0;
        check("mid_flush", 64'(flush_o), 64'd1);
        n_rst_i = 0;
        tick();
        check("abort_flush", 64'(flush_o), 64'd0);
        check("abort_pc", 64'(trap_pc_o), 64'(RST_PC));
        n_rst_i = 1;
        tick();
        check("abort_run", 64'(flush_o), 64'd0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            n_rst_i         = ($urandom_range(199) != 0);
            stall_req_if_i  = ($urandom_range(3) == 0);
            stall_req_id_i  = ($urandom_range(3) == 0);
            stall_req_ex_i  = ($urandom_range(3) == 0);
            stall_req_mem_i = ($urandom_range(2) == 0);
            trap_req_i      = ($urandom_range(9) == 0);
            mret_req_i      = ($urandom_range(7) == 0);
            if ($urandom_range(4) == 0) irq_i = ~irq_i;
            irq_en_i        = ($urandom_range(6) != 0);
            trap_vec_i      = $urandom;
            mepc_i          = $urandom;
            mem_pc_i        = $urandom;
            tick();
        end
        n_rst_i = 1;
        idle();
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by the fetch unit and the downstream pipeline registers. It also sequences control-flow redirects (synchronous traps, external interrupts, `mret`) into a flush pulse plus the redirect PC (`trap_pc_o`) that the fetch unit loads. It sits beside the CSR unit and drives `stall_i`, `flush_i` and `trap_pc_i` of the fetch unit.

## Interface
- `ADDR_W`, 32: PC/address width (matches `InstAddrBus`).
- `FLUSH_CYCLES`, 1: cycles `flush_o` is held per redirect; legal range 1–7.
- `RESET_PC`, `REBOOT_ADDR`: reset value of `trap_pc_o`.

Ports:
- `clk_i`  in  1  core clock.
- `n_rst_i`  in  1  reset; synchronous, active-low.
- `stall_req_if_i`, `stall_req_id_i`, `stall_req_ex_i`, `stall_req_mem_i`  in  1 each  per-stage stall requests.
- `trap_req_i`  in  1  synchronous exception reported by the MEM stage.
- `trap_vec_i`  in  ADDR_W  trap vector (mtvec) from CSR.
- `mret_req_i`  in  1  `mret` retiring in MEM.
- `mepc_i`  in  ADDR_W  return address from CSR.
- `irq_i`  in  1  level-sensitive external interrupt.
- `irq_en_i`  in  1  global interrupt enable (mstatus.MIE).
- `mem_pc_i`  in  ADDR_W  PC of the instruction in MEM.
- `stall_o`  out  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush_o`  out  1  flush all stages and load `trap_pc_o`.
- `trap_pc_o`  out  ADDR_W  redirect PC.
- `epc_o`  out  ADDR_W  PC to save into mepc.
- `epc_we_o`  out  1  one-cycle mepc write strobe.
- `irq_ack_o`  out  1  one-cycle interrupt-taken pulse.

## Operation
- FSM states: RUN, IRQ_WAIT, FLUSH. A 3-bit down-counter `fcnt` is used in FLUSH.
- Stall vector (combinational, RUN and IRQ_WAIT only), highest requester wins:
  - MEM → 011111
  - EX → 001111
  - ID → 000111
  - IF → 000011
  - none → 000000
- In FLUSH, `stall_o` = 000000, because flush overrides stall.
- Event priority in RUN/IRQ_WAIT: trap > irq (`irq_i & irq_en_i`) > mret.
- Trap taken:
  - `trap_pc_o` ← `trap_vec_i`, `epc_o` ← `mem_pc_i`.
  - Pulse `epc_we_o`.
  - Enter FLUSH with `fcnt` = FLUSH_CYCLES−1.
- Irq taken:
  - Taken only when `stall_req_mem_i` = 0.
  - Same actions as a trap, plus pulse `irq_ack_o`.
  - If `stall_req_mem_i` = 1 in RUN, go to IRQ_WAIT.
- IRQ_WAIT:
  - Stalls still apply.
  - Irq is taken on the first cycle with `stall_req_mem_i` = 0.
  - If `irq_i` or `irq_en_i` drops first, return to RUN without action.
  - A trap arriving in IRQ_WAIT is taken instead of the irq.
- Mret taken: `trap_pc_o` ← `mepc_i`. No `epc_we_o`. Enter FLUSH.
- FLUSH:
  - `flush_o` = 1.
  - `fcnt` decrements; return to RUN when `fcnt` = 0.
  - `trap_req_i` and `mret_req_i` are ignored, since their instructions are being flushed.
  - `irq_i` is re-evaluated only after returning to RUN.
- `trap_pc_o` holds its last value outside redirects.

## Timing
- Event inputs are sampled at rising edge E.
- `flush_o`, `trap_pc_o`, `epc_o` are valid from edge E for exactly FLUSH_CYCLES cycles.
- `epc_we_o` and `irq_ack_o` are high only for the cycle after E.
- `stall_o` has zero-cycle latency from the request inputs. This is a combinational path and must stay shallow.
- Back-to-back events: the earliest next redirect is sampled at the first edge after FLUSH exits, giving FLUSH_CYCLES+1 cycles between flush starts.
- Reset values, applied at the first edge with `n_rst_i` = 0:
  - state RUN, `fcnt` 0
  - `flush_o` 0, `epc_we_o` 0, `irq_ack_o` 0
  - `trap_pc_o` RESET_PC, `epc_o` 0
  - `stall_o` 000000 while the stall requests are low
- Reset asserted mid-FLUSH aborts the flush immediately at that edge.
- The fetch unit sees `flush_o` and `trap_pc_o` at the same edge and loads the PC on the next one.

## Structure
- Shared defines header gains:
  - stall vector constants (`STALL_NONE`, `STALL_FROM_IF/ID/EX/MEM`)
  - FSM state encodings
  - `REBOOT_ADDR` (already present)
- Single module, no sub-modules. Priority encode and FSM fit in about 200 lines.

## Test plan
- Stall merge: `stall_req_id_i` = 1 and `stall_req_mem_i` = 1 in the same cycle → `stall_o` = 011111. Drop MEM → 000111 in the same cycle.
- Trap: `trap_req_i` with `trap_vec_i` = 0x8000_0100, `mem_pc_i` = 0x0000_0040, FLUSH_CYCLES = 2 → `flush_o` high for 2 cycles, `trap_pc_o` = 0x8000_0100, `epc_o` = 0x40, `epc_we_o` high for 1 cycle.
- Irq deferral: `irq_i` = 1, `irq_en_i` = 1, `stall_req_mem_i` held high for 3 cycles → no flush during that time. On the first cycle MEM stall drops, `irq_ack_o`, `epc_we_o` and `flush_o` all assert.
- Simultaneous trap, irq and mret → trap taken, `irq_ack_o` = 0, `trap_pc_o` = `trap_vec_i`. After FLUSH with `irq_i` still high, the irq is taken on the next event.
- Mret: `mepc_i` = 0x0000_1234 → `trap_pc_o` = 0x1234, `flush_o` = 1, `epc_we_o` stays 0. A `trap_req_i` pulse during FLUSH is ignored.
- Reset mid-FLUSH: `n_rst_i` low for 1 cycle while `flush_o` = 1 → at that edge `flush_o` = 0 and `trap_pc_o` = RESET_PC; the FSM is in RUN afterwards.
